serial_adder: RTL and testbench

- Bit-serial, LSB-first adder for WIDTH-bit unsigned operands with carry-in.
- Sits directly downstream of half_adder. Each cycle one full-adder bit is formed from two half_adder instances plus an OR, and the carry is fed back through a register.
- Used where area matters more than latency. One result per WIDTH+1 cycles, with a start/busy/done handshake.

---
 rtl/half_adder.sv | 15 +
 rtl/serial_adder.sv | 122 ++++++++++++
 tb/tb_serial_adder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/half_adder.sv
// One-bit half adder: s = a ^ b, c = a & b.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Pure combinational sum/carry of two bits
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder bit per clock, carry held in a
// register, result {cout,sum} = a + b + cin after WIDTH processing cycles.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              cy_q, cy_d;
    logic              cout_q, cout_d;

    logic ha1_s, ha1_c, ha2_c, bit_s, bit_c;

    // Full-adder bit built from two half adders and an OR
    half_adder u_ha1 (
        .a (opa_q[0]),
        .b (opb_q[0]),
        .s (ha1_s),
        .c (ha1_c)
    );

    half_adder u_ha2 (
        .a (ha1_s),
        .b (cy_q),
        .s (bit_s),
        .c (ha2_c)
    );

    assign bit_c = ha1_c | ha2_c;

    // Next-state: operand load on accept, shift/accumulate while running
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    cy_d    = cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // New sum bit enters at the MSB so the LSB ends up at bit 0
                acc_d = WIDTH'({bit_s, acc_q} >> 1);
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                cy_d  = bit_c;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    sum_d   = acc_d;
                    cout_d  = bit_c;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            cout_q  <= cout_d;
        end
    end

    // Status decoded from the registered state; result from its own registers
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (WIDTH 8, 4, 1) checked every cycle
// against a transaction-level model, plus literal expectations for the
// directed cases.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_r [3];
    logic [31:0] a_r     [3];
    logic [31:0] b_r     [3];
    logic        cin_r   [3];

    logic        d_busy [3];
    logic        d_done [3];
    logic [31:0] d_sum  [3];
    logic        d_cout [3];

    logic [7:0] sum8;
    logic [3:0] sum4;
    logic [0:0] sum1;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_r[0]),
        .a     (a_r[0][7:0]),
        .b     (b_r[0][7:0]),
        .cin   (cin_r[0]),
        .busy  (d_busy[0]),
        .done  (d_done[0]),
        .sum   (sum8),
        .cout  (d_cout[0])
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_r[1]),
        .a     (a_r[1][3:0]),
        .b     (b_r[1][3:0]),
        .cin   (cin_r[1]),
        .busy  (d_busy[1]),
        .done  (d_done[1]),
        .sum   (sum4),
        .cout  (d_cout[1])
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_r[2]),
        .a     (a_r[2][0:0]),
        .b     (b_r[2][0:0]),
        .cin   (cin_r[2]),
        .busy  (d_busy[2]),
        .done  (d_done[2]),
        .sum   (sum1),
        .cout  (d_cout[2])
    );

    assign d_sum[0] = {24'd0, sum8};
    assign d_sum[1] = {28'd0, sum4};
    assign d_sum[2] = {31'd0, sum1};

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int wid(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 4 : 1);
    endfunction

    function automatic logic [63:0] msk(input int k);
        return (64'd1 << wid(k)) - 64'd1;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Transaction model: an accepted request keeps the unit busy for WIDTH
    // cycles, then shows a + b + cin for one done cycle and holds it.
    int          m_left [3];
    logic        m_done [3];
    logic [31:0] m_sum  [3];
    logic        m_cout [3];
    logic [63:0] m_res  [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_left[k] <= 0;
                m_done[k] <= 1'b0;
                m_sum[k]  <= '0;
                m_cout[k] <= 1'b0;
                m_res[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_done[k] <= 1'b0;
                if (m_left[k] == 0) begin
                    if (start_r[k]) begin
                        m_left[k] <= wid(k);
                        m_res[k]  <= ({32'd0, a_r[k]} & msk(k)) + ({32'd0, b_r[k]} & msk(k))
                                     + {63'd0, cin_r[k]};
                    end
                end else begin
                    m_left[k] <= m_left[k] - 1;
                    if (m_left[k] == 1) begin
                        m_done[k] <= 1'b1;
                        m_sum[k]  <= m_res[k][31:0] & msk(k)[31:0];
                        m_cout[k] <= m_res[k][wid(k)];
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("w%0d busy", wid(k)), {63'd0, d_busy[k]}, {63'd0, m_left[k] != 0});
            check($sformatf("w%0d done", wid(k)), {63'd0, d_done[k]}, {63'd0, m_done[k]});
            check($sformatf("w%0d sum", wid(k)), {32'd0, d_sum[k]}, {32'd0, m_sum[k]});
            check($sformatf("w%0d cout", wid(k)), {63'd0, d_cout[k]}, {63'd0, m_cout[k]});
        end
    end

    // One-cycle start pulse; operands scrambled afterwards
    task automatic run_op(input int k, input logic [31:0] ia, input logic [31:0] ib,
                          input logic ic);
        @(negedge clk);
        start_r[k] = 1'b1;
        a_r[k] = ia;
        b_r[k] = ib;
        cin_r[k] = ic;
        @(negedge clk);
        start_r[k] = 1'b0;
        a_r[k] = $urandom;
        b_r[k] = $urandom;
        cin_r[k] = 1'($urandom_range(0, 1));
    endtask

    // Bounded wait for the next done pulse; n counts negedges stepped
    task automatic wait_done(input int k, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_done[k] && n < 64);
    endtask

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic [7:0] es, input logic ec, input string nm);
        int n;
        run_op(0, {24'd0, ia}, {24'd0, ib}, ic);
        wait_done(0, n);
        check({nm, " latency"}, 64'(n), 64'd8);
        check({nm, " sum"}, {56'd0, sum8}, {56'd0, es});
        check({nm, " cout"}, {63'd0, d_cout[0]}, {63'd0, ec});
    endtask

    initial begin
        int n;
        int pulses;
        for (int k = 0; k < 3; k++) begin
            start_r[k] = 1'b0;
            a_r[k] = '0;
            b_r[k] = '0;
            cin_r[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset busy", {63'd0, d_busy[0]}, 64'd0);
        check("reset done", {63'd0, d_done[0]}, 64'd0);
        check("reset sum", {56'd0, sum8}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff+01");
        op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5+5a+1");
        op8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "3c+0f");

        // Start pulse while running must be ignored
        run_op(0, 32'h12, 32'h34, 1'b0);
        repeat (2) @(negedge clk);
        start_r[0] = 1'b1;
        a_r[0] = 32'hFF;
        b_r[0] = 32'hFF;
        @(negedge clk);
        start_r[0] = 1'b0;
        wait_done(0, n);
        check("ignored sum", {56'd0, sum8}, 64'h46);
        check("ignored cout", {63'd0, d_cout[0]}, 64'd0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            pulses += int'(d_done[0]);
        end
        check("ignored extra done", 64'(pulses), 64'd0);

        // Back-to-back with start held high
        @(negedge clk);
        start_r[0] = 1'b1;
        a_r[0] = 32'h01;
        b_r[0] = 32'h01;
        cin_r[0] = 1'b0;
        wait_done(0, n);
        check("b2b first gap", 64'(n), 64'd9);
        check("b2b first sum", {56'd0, sum8}, 64'h02);
        check("b2b first cout", {63'd0, d_cout[0]}, 64'd0);
        a_r[0] = 32'h80;
        b_r[0] = 32'h80;
        wait_done(0, n);
        check("b2b period", 64'(n), 64'd9);
        check("b2b second sum", {56'd0, sum8}, 64'h00);
        check("b2b second cout", {63'd0, d_cout[0]}, 64'd1);
        start_r[0] = 1'b0;
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of a run
        op8(8'hC3, 8'h11, 1'b0, 8'hD4, 1'b0, "pre-reset");
        run_op(0, 32'h77, 32'h99, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", {63'd0, d_busy[0]}, 64'd0);
        check("async rst done", {63'd0, d_done[0]}, 64'd0);
        check("async rst sum", {56'd0, sum8}, 64'd0);
        check("async rst cout", {63'd0, d_cout[0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            pulses += int'(d_done[0]);
        end
        check("aborted op done", 64'(pulses), 64'd0);
        op8(8'h05, 8'h06, 1'b0, 8'h0B, 1'b0, "05+06");

        // Exhaustive narrow widths
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run_op(1, 32'(ia), 32'(ib), 1'(ic));
                    wait_done(1, n);
                    check("w4 latency", 64'(n), 64'd4);
                    check("w4 result", {59'd0, d_cout[1], sum4}, 64'(ia + ib + ic));
                end
            end
        end
        for (int ia = 0; ia < 2; ia++) begin
            for (int ib = 0; ib < 2; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run_op(2, 32'(ia), 32'(ib), 1'(ic));
                    wait_done(2, n);
                    check("w1 latency", 64'(n), 64'd1);
                    check("w1 result", {62'd0, d_cout[2], sum1}, 64'(ia + ib + ic));
                end
            end
        end

        // Random traffic on all instances, checked by the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                start_r[k] = ($urandom_range(0, 3) == 0);
                a_r[k] = $urandom;
                b_r[k] = $urandom;
                cin_r[k] = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) start_r[k] = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
